// File: rtl/exe_div_pkg.sv
// Shared types for the EX-stage divide issue controller and its result buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package exe_div_pkg;

    // Controller states: waiting for an op, divider running, result held for MEM
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Bit positions inside the 2-bit op field
    localparam int OP_MOD = 0;  // 1 = return remainder, 0 = return quotient
    localparam int OP_UNS = 1;  // 1 = unsigned divide, 0 = signed divide

    // Quotient reported for a zero divisor (matches the divider's own answer)
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_div_out_buf.sv
// Result hold register between EX and MEM: captures one bundle, presents it until MEM takes it.
// Latency: a bundle loaded at edge T is valid from T (registered), i.e. visible the cycle after load.
// Backpressure: holds valid and data while out_allowin=0; in_allowin = empty or draining this cycle.
module exe_div_out_buf #(
    parameter int W = 69
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    output logic         in_allowin,
    output logic         out_valid,
    output logic [W-1:0] out_dat,
    input  logic         out_allowin
);

    logic         vld;
    logic [W-1:0] dat;

    // Valid tracking: flush discards, a load (re)fills, a MEM handshake empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (out_allowin) begin
            vld <= 1'b0;
        end
    end

    // Data capture: only on a load that is not being flushed; otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat <= '0;
        end else if (load && !flush) begin
            dat <= load_dat;
        end
    end

    assign in_allowin = !vld || out_allowin;
    assign out_valid  = vld;
    assign out_dat    = dat;

endmodule

// File: rtl/exe_div_issue.sv
// EX-stage issue/hold controller for DIV.W/MOD.W/DIV.WU/MOD.WU between the ID->EX bundle and the divider.
// Latency: accept at T -> div_req from T+1; es_to_ms_valid the cycle after div_complete.
// Backpressure: result held while ms_allowin=0; es_allowin only in IDLE or DONE-and-draining; flush squashes.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer zero-divisor ops without starting the divider.
module exe_div_issue
    import exe_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_to_es_valid,
    output logic              es_allowin,
    input  logic [1:0]        ds_op,
    input  logic [DATA_W-1:0] ds_src1,
    input  logic [DATA_W-1:0] ds_src2,
    input  logic [DEST_W-1:0] ds_dest,
    input  logic [PC_W-1:0]   ds_pc,
    input  logic              flush,
    output logic              div_req,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_x,
    output logic [DATA_W-1:0] div_y,
    input  logic [DATA_W-1:0] div_s,
    input  logic [DATA_W-1:0] div_r,
    input  logic              div_complete,
    output logic              div_cancel,
    output logic              es_to_ms_valid,
    input  logic              ms_allowin,
    output logic [DATA_W-1:0] es_result,
    output logic [DEST_W-1:0] es_dest,
    output logic [PC_W-1:0]   es_pc
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DEST_W-1:0] dest;
        logic [PC_W-1:0]   pc;
    } es_bundle_t;

    div_state_t        state;
    div_state_t        state_nxt;

    logic [1:0]        op_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [DEST_W-1:0] dest_q;
    logic [PC_W-1:0]   pc_q;

    logic              accept;
    logic              zero_bypass;
    logic              buf_load;
    logic              buf_allowin;
    es_bundle_t        buf_in;
    es_bundle_t        buf_out;

    // A flush in the same cycle blocks the handshake even though es_allowin may be high
    assign accept = ds_to_es_valid && es_allowin && !flush;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = accept && (ds_src2 == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    // Only IDLE, or DONE while MEM is taking the held bundle, can take a new op
    assign es_allowin = (state != BUSY) && buf_allowin;

    // Operand latch: keeps the divider inputs stable for the whole divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dest_q <= '0;
            pc_q   <= '0;
        end else if (accept) begin
            op_q   <= ds_op;
            src1_q <= ds_src1;
            src2_q <= ds_src2;
            dest_q <= ds_dest;
            pc_q   <= ds_pc;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush beats everything, then a new accept, then completion/drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = zero_bypass ? DONE : BUSY;
                end else if ((state == DONE) && ms_allowin) begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (div_complete) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bundle source: divider output selected by op, or the fixed zero-divisor answer on bypass
    always_comb begin
        buf_in.result = op_q[OP_MOD] ? div_r : div_s;
        buf_in.dest   = dest_q;
        buf_in.pc     = pc_q;
        if (zero_bypass) begin
            buf_in.result = ds_op[OP_MOD] ? ds_src1 : DATA_W'(DIV_ZERO_Q);
            buf_in.dest   = ds_dest;
            buf_in.pc     = ds_pc;
        end
    end

    // A completion that coincides with a flush is dropped rather than captured
    assign buf_load = ((state == BUSY) && div_complete && !flush) || zero_bypass;

    // div_req follows BUSY, so it is low for at least the DONE/IDLE cycle between ops
    assign div_req    = (state == BUSY);
    assign div_signed = !op_q[OP_UNS];
    assign div_x      = src1_q;
    assign div_y      = src2_q;
    // Cancel only a divide still running; a finished one needs no abort
    assign div_cancel = (state == BUSY) && flush && !div_complete;

    exe_div_out_buf #(
        .W ($bits(es_bundle_t))
    ) u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .load        (buf_load),
        .load_dat    (buf_in),
        .in_allowin  (buf_allowin),
        .out_valid   (es_to_ms_valid),
        .out_dat     (buf_out),
        .out_allowin (ms_allowin)
    );

    assign es_result = buf_out.result;
    assign es_dest   = buf_out.dest;
    assign es_pc     = buf_out.pc;

endmodule
